// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the RV32I branch predictor / resolver.
//   branch_funct3_e : B-type condition codes (010/011 are not branches)
//   btb_entry_t     : one BTB line; tag is stored zero-extended to RV_XLEN
//   BHT_RESET/ALLOC : 2-bit counter value after reset / on a fresh allocation
package rv32_branch_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_funct3_e;

  typedef struct packed {
    logic               valid;
    logic               jump;
    logic [RV_XLEN-1:0] tag;
    logic [RV_XLEN-1:0] target;
  } btb_entry_t;

  localparam logic [1:0] BHT_RESET = 2'b01;
  localparam logic [1:0] BHT_ALLOC = 2'b10;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-resolve bus of the branch predictor.
//   slave  : seen by branch_predict_unit (fetch PC + execute operands in, prediction out)
//   master : seen by the pipeline driving it
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_if;
  logic            pred_taken_if;
  logic [XLEN-1:0] pred_pc_if;
  logic            ex_valid;
  logic [XLEN-1:0] pc_ex;
  logic            b_type;
  logic            op_jal;
  logic            op_jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [20:0]     imm21_j;
  logic [11:0]     imm12_i;
  logic [12:0]     imm13_b;
  logic            pred_taken_ex;
  logic [XLEN-1:0] pred_pc_ex;

  modport slave (
    input  pc_if, ex_valid, pc_ex, b_type, op_jal, op_jalr, funct3,
           rs1_val, rs2_val, imm21_j, imm12_i, imm13_b, pred_taken_ex, pred_pc_ex,
    output pred_taken_if, pred_pc_if
  );

  modport master (
    output pc_if, ex_valid, pc_ex, b_type, op_jal, op_jalr, funct3,
           rs1_val, rs2_val, imm21_j, imm12_i, imm13_b, pred_taken_ex, pred_pc_ex,
    input  pred_taken_if, pred_pc_if
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry 2-bit BHT counter.
//   rd_pc_i -> rd_taken_o/rd_target_o : combinational lookup (pre-update contents)
//   wr_*_i                            : training write, applied on the clock edge
// Only valid bits and BHT counters are reset; tag/target are qualified by valid.
module branch_target_buffer
  import rv32_branch_pkg::*;
#(
  parameter int XLEN    = RV_XLEN,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_taken_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            wr_branch_i,
  input  logic            wr_jump_i,
  input  logic            wr_taken_i,
  input  logic [XLEN-1:0] wr_target_i
);
  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t btb_q [ENTRIES];
  logic [1:0] bht_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [XLEN-1:0]  rd_tag, wr_tag;
  btb_entry_t       rd_entry, wr_entry;
  logic             rd_hit, wr_hit;
  logic [3:0]       unused_pc_lo;

  function automatic logic [1:0] bht_next(logic [1:0] cnt, logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign unused_pc_lo = {rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_idx   = rd_pc_i[IDX_W+1:2];
  assign rd_tag   = {{(IDX_W+2){1'b0}}, rd_pc_i[XLEN-1:IDX_W+2]};
  assign rd_entry = btb_q[rd_idx];
  assign rd_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);

  assign rd_taken_o  = rd_hit && (rd_entry.jump || bht_q[rd_idx][1]);
  assign rd_target_o = rd_entry.target;

  assign wr_idx   = wr_pc_i[IDX_W+1:2];
  assign wr_tag   = {{(IDX_W+2){1'b0}}, wr_pc_i[XLEN-1:IDX_W+2]};
  assign wr_entry = btb_q[wr_idx];
  assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

  // Training stage: result of execute written at the edge, visible next cycle
  always_ff @(posedge clk) begin
    if (!rstB) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
        bht_q[i]       <= BHT_RESET;
      end
    end else if (wr_en_i) begin
      if (wr_branch_i || wr_jump_i) begin
        if (wr_hit) begin
          if (wr_jump_i) begin
            btb_q[wr_idx].target <= wr_target_i;
            btb_q[wr_idx].jump   <= 1'b1;
          end else begin
            bht_q[wr_idx] <= bht_next(bht_q[wr_idx], wr_taken_i);
            if (wr_taken_i) btb_q[wr_idx].target <= wr_target_i;
          end
        end else if (wr_taken_i) begin
          btb_q[wr_idx].valid  <= 1'b1;
          btb_q[wr_idx].jump   <= wr_jump_i;
          btb_q[wr_idx].tag    <= wr_tag;
          btb_q[wr_idx].target <= wr_target_i;
          bht_q[wr_idx]        <= BHT_ALLOC;
        end
      end else if (wr_hit) begin
        // A non-control instruction must never predict taken again.
        btb_q[wr_idx].valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// RV32I branch resolution + BTB/BHT next-PC predictor.
//   clk, rstB (sync, active-low)
//   bp          : fetch lookup and execute-resolve bus (slave side)
//   pc_return   : pc_ex+4 for JAL/JALR, else 0 (combinational)
//   flush       : one-cycle registered mispredict pulse
//   redirect_pc : correct next PC while flush=1
//   branch_cnt  : resolved control transfers; mispred_cnt : mispredicts
// While flush=1 the execute slot holds a wrong-path instruction and is ignored.
module branch_predict_unit
  import rv32_branch_pkg::*;
#(
  parameter int XLEN        = RV_XLEN,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rstB,
  branch_predict_unit_if.slave bp,
  output logic [XLEN-1:0]   pc_return,
  output logic              flush,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);
  logic            flush_q, flush_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  logic            is_jump, is_ctrl, cond, act_taken, ex_live, mispred;
  logic [XLEN-1:0] br_target, jal_target, jalr_target, act_target, act_pc, seq_pc;
  logic            lk_taken;
  logic [XLEN-1:0] lk_target;
  logic            unused_pred_taken;

  function automatic logic [XLEN-1:0] sext13(logic [12:0] v);
    return {{(XLEN-13){v[12]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext12(logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext21(logic [20:0] v);
    return {{(XLEN-21){v[20]}}, v};
  endfunction

  function automatic logic branch_cond(logic [2:0] f3, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      BEQ:     return a == b;
      BNE:     return a != b;
      BLT:     return sa < sb;
      BGE:     return sa >= sb;
      BLTU:    return a < b;
      BGEU:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // The mispredict decision uses only the predicted next PC.
  assign unused_pred_taken = bp.pred_taken_ex;

  // Fetch lookup
  branch_target_buffer #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES)) u_btb (
    .clk         (clk),
    .rstB        (rstB),
    .rd_pc_i     (bp.pc_if),
    .rd_taken_o  (lk_taken),
    .rd_target_o (lk_target),
    .wr_en_i     (ex_live),
    .wr_pc_i     (bp.pc_ex),
    .wr_branch_i (bp.b_type && !is_jump),
    .wr_jump_i   (is_jump),
    .wr_taken_i  (act_taken),
    .wr_target_i (act_target)
  );

  assign bp.pred_taken_if = lk_taken;
  assign bp.pred_pc_if    = lk_taken ? lk_target : bp.pc_if + XLEN'(4);

  // Execute resolve
  assign is_jump     = bp.op_jal || bp.op_jalr;
  assign is_ctrl     = is_jump || bp.b_type;
  assign cond        = branch_cond(bp.funct3, bp.rs1_val, bp.rs2_val);
  assign seq_pc      = bp.pc_ex + XLEN'(4);
  assign br_target   = bp.pc_ex + sext13(bp.imm13_b);
  assign jal_target  = bp.pc_ex + sext21(bp.imm21_j);
  assign jalr_target = (bp.rs1_val + sext12(bp.imm12_i)) & ~XLEN'(1);
  assign act_target  = bp.op_jal ? jal_target : (bp.op_jalr ? jalr_target : br_target);
  assign act_taken   = is_jump || (bp.b_type && cond);
  assign act_pc      = act_taken ? act_target : seq_pc;
  assign pc_return   = is_jump ? seq_pc : '0;

  assign ex_live = bp.ex_valid && !flush_q;
  assign mispred = ex_live && (bp.pred_pc_ex != act_pc);

  always_comb begin
    flush_d       = mispred;
    redirect_d    = mispred ? act_pc : redirect_q;
    branch_cnt_d  = branch_cnt_q + {{(CNT_W-1){1'b0}}, ex_live && is_ctrl};
    mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, mispred};
  end

  // Mispredict register stage
  always_ff @(posedge clk) begin
    if (!rstB) begin
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit (4-entry BTB, 4-bit counters): directed cases
// followed by randomized traffic, all checked against a table-level model.
module tb_branch_predict_unit;
  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;
  localparam int CMASK = 15;

  logic        clk = 1'b0;
  logic        rstB;
  logic [31:0] pc_return, redirect_pc;
  logic        flush;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predict_unit_if #(.XLEN(32)) bp ();

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstB        (rstB),
    .bp          (bp.slave),
    .pc_return   (pc_return),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          mv [N];
  bit          mj [N];
  logic [31:0] mtag [N];
  logic [31:0] mt [N];
  int          mb [N];
  bit          m_flush;
  logic [31:0] m_redir;
  int          m_bcnt, m_mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mj[i] = 0; mb[i] = 1; mtag[i] = 0; mt[i] = 0;
    end
    m_flush = 0; m_redir = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic model_look(input logic [31:0] pc, output bit tk, output logic [31:0] npc);
    int idx;
    bit hit;
    idx = int'((pc >> 2) % N);
    hit = mv[idx] && (mtag[idx] == (pc >> (IDX_W + 2)));
    tk  = hit && (mj[idx] || mb[idx] >= 2);
    npc = tk ? mt[idx] : pc + 32'd4;
  endtask

  task automatic model_step();
    bit          live, taken, c, hit, mis, ctrl;
    logic [31:0] pc, a, b, tgt, act;
    int          idx;
    pc = bp.pc_ex; a = bp.rs1_val; b = bp.rs2_val;
    case (bp.funct3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) < $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: c = 0;
    endcase
    if (bp.op_jal)       tgt = pc + 32'(int'($signed(bp.imm21_j)));
    else if (bp.op_jalr) tgt = (a + 32'(int'($signed(bp.imm12_i)))) & 32'hFFFF_FFFE;
    else                 tgt = pc + 32'(int'($signed(bp.imm13_b)));
    ctrl  = bp.op_jal || bp.op_jalr || bp.b_type;
    taken = bp.op_jal || bp.op_jalr || (bp.b_type && c);
    act   = taken ? tgt : pc + 32'd4;
    live  = bp.ex_valid && !m_flush;
    mis   = live && (bp.pred_pc_ex != act);
    if (mis) m_redir = act;
    if (live) begin
      if (ctrl) m_bcnt = (m_bcnt + 1) & CMASK;
      if (mis)  m_mcnt = (m_mcnt + 1) & CMASK;
      idx = int'((pc >> 2) % N);
      hit = mv[idx] && (mtag[idx] == (pc >> (IDX_W + 2)));
      if (ctrl) begin
        if (hit) begin
          if (bp.op_jal || bp.op_jalr) begin
            mt[idx] = tgt; mj[idx] = 1;
          end else begin
            mb[idx] = taken ? ((mb[idx] < 3) ? mb[idx] + 1 : 3) : ((mb[idx] > 0) ? mb[idx] - 1 : 0);
            if (taken) mt[idx] = tgt;
          end
        end else if (taken) begin
          mv[idx] = 1; mtag[idx] = pc >> (IDX_W + 2); mt[idx] = tgt;
          mj[idx] = bp.op_jal || bp.op_jalr; mb[idx] = 2;
        end
      end else if (hit) begin
        mv[idx] = 0;
      end
    end
    m_flush = mis;
  endtask

  // One clock: check everything against the model mid-cycle, advance model, cross the edge.
  task automatic cycle();
    bit          etk;
    logic [31:0] epc;
    #4;
    model_look(bp.pc_if, etk, epc);
    chk("pred_tk", 32'(bp.pred_taken_if), 32'(etk));
    chk("pred_pc", bp.pred_pc_if, epc);
    chk("pc_ret", pc_return, (bp.op_jal || bp.op_jalr) ? bp.pc_ex + 32'd4 : 32'd0);
    chk("flush", 32'(flush), 32'(m_flush));
    if (m_flush) chk("redir", redirect_pc, m_redir);
    chk("bcnt", 32'(branch_cnt), 32'(m_bcnt));
    chk("mcnt", 32'(mispred_cnt), 32'(m_mcnt));
    if (!rstB) model_reset();
    else       model_step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 non-control, 1 B-type, 2 JAL, 3 JALR
  task automatic drive(input bit v, input logic [31:0] pc, input int kind, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] ppc);
    bp.ex_valid      = v;
    bp.pc_ex         = pc;
    bp.b_type        = (kind == 1);
    bp.op_jal        = (kind == 2);
    bp.op_jalr       = (kind == 3);
    bp.funct3        = f3;
    bp.rs1_val       = a;
    bp.rs2_val       = b;
    bp.imm21_j       = imm[20:0];
    bp.imm12_i       = imm[11:0];
    bp.imm13_b       = imm[12:0];
    bp.pred_pc_ex    = ppc;
    bp.pred_taken_ex = (ppc != pc + 32'd4);
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h4);
    cycle();
  endtask

  initial begin
    bit          tk;
    logic [31:0] npc, pc, a, b;
    int          r;

    rstB = 1'b0;
    bp.pc_if = 32'h100;
    drive(0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rstB = 1'b1;

    // Reset state
    chk("t1_ptk", 32'(bp.pred_taken_if), 32'h0);
    chk("t1_ppc", bp.pred_pc_if, 32'h104);
    chk("t1_flush", 32'(flush), 32'h0);
    chk("t1_redir", redirect_pc, 32'h0);
    chk("t1_cnt", 32'({branch_cnt, mispred_cnt}), 32'h0);
    cycle();

    // BEQ taken, predicted not-taken
    drive(1, 32'h100, 1, 3'd0, 32'd5, 32'd5, 32'h1FF8, 32'h104);
    cycle();
    chk("t2_flush", 32'(flush), 32'h1);
    chk("t2_redir", redirect_pc, 32'hF8);
    bp.ex_valid = 1'b0;
    #1;
    chk("t2_ppc", bp.pred_pc_if, 32'hF8);
    cycle();

    // BLTU / BLT / BGE
    drive(1, 32'h200, 1, 3'd6, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h204);
    cycle();
    chk("t3_bltu_fl", 32'(flush), 32'h1);
    chk("t3_bltu_rd", redirect_pc, 32'h220);
    idle();
    drive(1, 32'h300, 1, 3'd4, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h304);
    cycle();
    chk("t3_blt_fl", 32'(flush), 32'h0);
    idle();
    drive(1, 32'h400, 1, 3'd5, 32'd7, 32'd7, 32'h40, 32'h404);
    cycle();
    chk("t3_bge_fl", 32'(flush), 32'h1);
    chk("t3_bge_rd", redirect_pc, 32'h440);
    idle();

    // BHT decay on a repeatedly not-taken branch
    bp.pc_if = 32'h500;
    drive(1, 32'h500, 1, 3'd0, 32'd3, 32'd3, 32'h10, 32'h504);
    cycle();
    idle();
    chk("t4_tk_alloc", 32'(bp.pred_taken_if), 32'h1);
    drive(1, 32'h500, 1, 3'd0, 32'd1, 32'd2, 32'h10, 32'h510);
    cycle();
    chk("t4_redir", redirect_pc, 32'h504);
    idle();
    chk("t4_tk_1", 32'(bp.pred_taken_if), 32'h0);
    repeat (2) begin
      drive(1, 32'h500, 1, 3'd0, 32'd1, 32'd2, 32'h10, 32'h504);
      cycle();
    end
    chk("t4_tk_3", 32'(bp.pred_taken_if), 32'h0);

    // JALR target / pc_return, then ignored wrong-path mispredict
    drive(1, 32'h600, 3, 3'd0, 32'h2001, 32'h0, 32'h10, 32'h604);
    #1;
    chk("t5_ret", pc_return, 32'h604);
    cycle();
    chk("t5_redir", redirect_pc, 32'h2010);
    drive(1, 32'h700, 2, 3'd0, 32'h0, 32'h0, 32'h100, 32'h704);
    cycle();
    chk("t5_noflush", 32'(flush), 32'h0);
    chk("t5_mcnt", 32'(mispred_cnt), 32'(m_mcnt));
    bp.ex_valid = 1'b0;
    bp.pc_if = 32'h700;
    #1;
    chk("t5_noalloc", 32'(bp.pred_taken_if), 32'h0);
    cycle();

    // Aliasing on a 4-entry table, then stale entry cleared by a non-control op
    drive(1, 32'h00, 2, 3'd0, 32'h0, 32'h0, 32'h40, 32'h04);
    cycle();
    idle();
    bp.pc_if = 32'h00;
    #1;
    chk("t6_first", bp.pred_pc_if, 32'h40);
    drive(1, 32'h10, 2, 3'd0, 32'h0, 32'h0, 32'h80, 32'h14);
    cycle();
    idle();
    chk("t6_evict_tk", 32'(bp.pred_taken_if), 32'h0);
    chk("t6_evict_pc", bp.pred_pc_if, 32'h04);
    bp.pc_if = 32'h10;
    #1;
    chk("t6_second", bp.pred_pc_if, 32'h90);
    drive(1, 32'h10, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h90);
    cycle();
    chk("t6_stale_rd", redirect_pc, 32'h14);
    idle();
    chk("t6_cleared", bp.pred_pc_if, 32'h14);

    // Reset in the same cycle as a mispredict
    drive(1, 32'h800, 2, 3'd0, 32'h0, 32'h0, 32'h20, 32'h804);
    rstB = 1'b0;
    cycle();
    rstB = 1'b1;
    chk("t7_flush", 32'(flush), 32'h0);
    chk("t7_cnt", 32'({branch_cnt, mispred_cnt}), 32'h0);
    bp.pc_if = 32'h800;
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rstB = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else                            pc = 32'h1000 + 32'($urandom_range(0, 31) * 4);
      bp.pc_if = 32'h1000 + 32'($urandom_range(0, 31) * 4);
      a = $urandom;
      r = $urandom_range(0, 2);
      b = (r == 0) ? a : ((r == 1) ? 32'($urandom_range(0, 3)) : $urandom);
      model_look(pc, tk, npc);
      r = $urandom_range(0, 3);
      if (r == 0)      npc = pc + 32'd4;
      else if (r == 3) npc = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      drive($urandom_range(0, 4) != 0, pc, $urandom_range(0, 3), 3'($urandom_range(0, 7)),
            a, b, $urandom, npc);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
